// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core.
// Fetches an instruction into the IR, decodes it, then sequences ALU, data memory, register
// writeback and PC update. Both memory ports use a req/ready handshake.
//
// Ports:
//   clk, reset         clock (rising edge) and asynchronous active-high reset
//   instr_code         instruction register contents, stable from DECODE to the next fetch
//   imem_ready         instruction memory data valid this cycle
//   dmem_ready         data memory access completes this cycle
//   branch_taken       branch comparator result
//   imem_req, ir_we    fetch request and instruction register load
//   dmem_req, dmem_we  data memory request and write enable
//   rf_we, pc_we       register file and PC write enables
//   pc_src             0: PC+4, 1: PC+imm, 2: ALU & ~1
//   alu_src_a          0: rs1, 1: PC, 2: zero
//   alu_src_b          0: rs2, 1: imm_ext
//   alu_op             {op_mod, funct3}
//   wb_sel             0: ALU, 1: load data, 2: PC+4
//   retired            pulse on the cycle an instruction completes
//   illegal            sticky: an unsupported encoding was decoded
module rv32i_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        retired,
  output logic        illegal
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StTrap
  } state_t;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_load, is_store, is_branch, is_jal, is_jalr;
  logic       legal;
  logic [1:0] alu_a_sel;
  logic       alu_b_sel;
  logic [3:0] alu_op_sel;
  logic       unused_bits;

  assign opcode    = instr_code[6:0];
  assign funct3    = instr_code[14:12];
  assign funct7_5  = instr_code[30];
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBr);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);

  // Register/immediate fields are consumed by the datapath, not by this controller.
  assign unused_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OpR, OpImm, OpLui, OpAuipc, OpJal: legal = 1'b1;
      OpLoad:  legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      OpStore: legal = (funct3 <= 3'b010);
      OpBr:    legal = !(funct3 == 3'b010 || funct3 == 3'b011);
      OpJalr:  legal = (funct3 == 3'b000);
      default: legal = 1'b0;
    endcase
  end

  // ALU selections; driven in EXECUTE and held through MEM (address) and JALR writeback.
  always_comb begin
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    alu_op_sel = 4'b0000;
    case (opcode)
      OpR: alu_op_sel = {funct7_5, funct3};
      OpImm: begin
        alu_b_sel  = 1'b1;
        // Only the shift-right encoding uses funct7[5]; for the others it is immediate data.
        alu_op_sel = {(funct3 == 3'b101) & funct7_5, funct3};
      end
      OpLoad, OpStore, OpJalr: alu_b_sel = 1'b1;
      OpLui: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 1'b1;
      end
      OpAuipc: begin
        alu_a_sel = 2'd1;
        alu_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  if (imem_ready) state_d = StDecode;
      StDecode: state_d = legal ? StExecute : StTrap;
      StExecute: begin
        if (is_branch)                 state_d = StFetch;
        else if (is_load || is_store)  state_d = StMem;
        else                           state_d = StWriteback;
      end
      StMem:       if (dmem_ready) state_d = is_store ? StFetch : StWriteback;
      StWriteback: state_d = StFetch;
      StTrap:      state_d = StTrap;
      default:     state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StStart;
    else       state_q <= state_d;
  end

  // Outputs decode straight from the state register so an asynchronous reset clears them at once.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    wb_sel    = 2'd0;
    retired   = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      StExecute: begin
        alu_src_a = alu_a_sel;
        alu_src_b = alu_b_sel;
        alu_op    = alu_op_sel;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? 2'd1 : 2'd0;
          retired = 1'b1;
        end
      end
      StMem: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        alu_src_a = alu_a_sel;
        alu_src_b = alu_b_sel;
        alu_op    = alu_op_sel;
        if (dmem_ready && is_store) begin
          pc_we   = 1'b1;
          retired = 1'b1;
        end
      end
      StWriteback: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retired = 1'b1;
        if (is_load) begin
          wb_sel = 2'd1;
        end else if (is_jal) begin
          wb_sel = 2'd2;
          pc_src = 2'd1;
        end else if (is_jalr) begin
          wb_sel    = 2'd2;
          pc_src    = 2'd2;
          alu_src_a = alu_a_sel;
          alu_src_b = alu_b_sel;
          alu_op    = alu_op_sel;
        end
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl. Each test pushes per-cycle stimulus with the
// expected output vector into a scoreboard queue, then pops and compares cycle by cycle.
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_code = 32'h0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0]  pc_src, alu_src_a, wb_sel;
  logic        alu_src_b, retired, illegal;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_code   (instr_code),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .retired      (retired),
    .illegal      (illegal)
  );

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        ir;
    logic        dr;
    logic        bt;
    logic [18:0] exp;
    string       tag;
  } step_t;

  step_t sb[$];

  // Vector order: imem_req ir_we dmem_req dmem_we rf_we pc_we pc_src a b op wb_sel retired illegal
  function automatic logic [18:0] v(input logic ireq, input logic irw, input logic dreq,
                                    input logic dwe, input logic rfw, input logic pcw,
                                    input logic [1:0] pcs, input logic [1:0] sa, input logic sbb,
                                    input logic [3:0] op, input logic [1:0] wb, input logic ret,
                                    input logic ill);
    return {ireq, irw, dreq, dwe, rfw, pcw, pcs, sa, sbb, op, wb, ret, ill};
  endfunction

  logic [18:0] e_zero, e_fetch, e_fetch_wait, e_wb_alu, e_trap;

  task automatic push(input logic rst, input logic [31:0] instr, input logic ir, input logic dr,
                      input logic bt, input logic [18:0] exp, input string tag);
    step_t s;
    s.rst = rst; s.instr = instr; s.ir = ir; s.dr = dr; s.bt = bt; s.exp = exp; s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic push_fd(input logic [31:0] instr);
    push(1'b0, instr, 1'b1, 1'b0, 1'b0, e_fetch, "fetch");
    push(1'b0, instr, 1'b1, 1'b0, 1'b0, e_zero, "decode");
  endtask

  task automatic drive_sample(input step_t s, output logic [18:0] obs);
    @(negedge clk);
    reset = s.rst; instr_code = s.instr; imem_ready = s.ir;
    dmem_ready = s.dr; branch_taken = s.bt;
    #1;
    obs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src, alu_src_a, alu_src_b,
           alu_op, wb_sel, retired, illegal};
  endtask

  task automatic test_reset();
    step_t s; logic [18:0] obs;
    push(1'b1, 32'h00500093, 1'b1, 1'b1, 1'b0, e_zero, "reset_hold0");
    push(1'b1, 32'h00500093, 1'b1, 1'b1, 1'b0, e_zero, "reset_hold1");
    push(1'b0, 32'h00500093, 1'b1, 1'b1, 1'b0, e_zero, "start");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_addi();
    step_t s; logic [18:0] obs;
    push_fd(32'h00500093);
    push(1'b0, 32'h00500093, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "addi_exec");
    push(1'b0, 32'h00500093, 1'b1, 1'b0, 1'b0, e_wb_alu, "addi_wb");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    step_t s; logic [18:0] obs;
    push_fd(32'h4020D093);
    push(1'b0, 32'h4020D093, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'hD,0,0,0), "srai_exec");
    push(1'b0, 32'h4020D093, 1'b1, 1'b0, 1'b0, e_wb_alu, "srai_wb");
    push_fd(32'h40208033);
    push(1'b0, 32'h40208033, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,4'h8,0,0,0), "sub_exec");
    push(1'b0, 32'h40208033, 1'b1, 1'b0, 1'b0, e_wb_alu, "sub_wb");
    // addi with immediate bit 30 set must not raise op_mod
    push_fd(32'h40008093);
    push(1'b0, 32'h40008093, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "addi30_exec");
    push(1'b0, 32'h40008093, 1'b1, 1'b0, 1'b0, e_wb_alu, "addi30_wb");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_load_wait();
    step_t s; logic [18:0] obs;
    push_fd(32'h0000A103);
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "lw_exec");
    for (int i = 0; i < 3; i++)
      push(1'b0, 32'h0000A103, 1'b1, 1'b0, 1'b0, v(0,0,1,0,0,0,0,0,1,4'h0,0,0,0), "lw_mem_wait");
    push(1'b0, 32'h0000A103, 1'b1, 1'b1, 1'b0, v(0,0,1,0,0,0,0,0,1,4'h0,0,0,0), "lw_mem_done");
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, 1'b0, v(0,0,0,0,1,1,0,0,0,4'h0,1,1,0), "lw_wb");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_branch();
    step_t s; logic [18:0] obs;
    push_fd(32'h00208463);
    push(1'b0, 32'h00208463, 1'b1, 1'b0, 1'b1, v(0,0,0,0,0,1,1,0,0,4'h0,0,1,0), "beq_taken");
    push_fd(32'h00208463);
    push(1'b0, 32'h00208463, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,1,0,0,0,4'h0,0,1,0), "beq_not");
    push(1'b0, 32'h00208463, 1'b0, 1'b0, 1'b0, e_fetch_wait, "beq_back_fetch");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_jumps_upper();
    step_t s; logic [18:0] obs;
    // Previous test left the FSM in FETCH with imem_ready low.
    push_fd(32'h000000E7);
    push(1'b0, 32'h000000E7, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "jalr_exec");
    push(1'b0, 32'h000000E7, 1'b1, 1'b0, 1'b0, v(0,0,0,0,1,1,2,0,1,4'h0,2,1,0), "jalr_wb");
    push_fd(32'h0080006F);
    push(1'b0, 32'h0080006F, 1'b1, 1'b0, 1'b0, e_zero, "jal_exec");
    push(1'b0, 32'h0080006F, 1'b1, 1'b0, 1'b0, v(0,0,0,0,1,1,1,0,0,4'h0,2,1,0), "jal_wb");
    push_fd(32'h123450B7);
    push(1'b0, 32'h123450B7, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,2,1,4'h0,0,0,0), "lui_exec");
    push(1'b0, 32'h123450B7, 1'b1, 1'b0, 1'b0, e_wb_alu, "lui_wb");
    push_fd(32'h00001097);
    push(1'b0, 32'h00001097, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,1,1,4'h0,0,0,0), "auipc_exec");
    push(1'b0, 32'h00001097, 1'b1, 1'b0, 1'b0, e_wb_alu, "auipc_wb");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_store_wait();
    step_t s; logic [18:0] obs;
    // dmem_ready during FETCH has no matching request and must be ignored.
    push(1'b0, 32'h0020A023, 1'b0, 1'b1, 1'b0, e_fetch_wait, "sw_fetch_wait");
    push_fd(32'h0020A023);
    push(1'b0, 32'h0020A023, 1'b1, 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "sw_exec");
    push(1'b0, 32'h0020A023, 1'b1, 1'b1, 1'b0, v(0,0,1,1,0,1,0,0,1,4'h0,0,1,0), "sw_mem");
    push(1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, e_fetch_wait, "sw_back_fetch");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t s; logic [18:0] obs;
    push_fd(32'h0020A023);
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "rsw_exec");
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, 1'b0, v(0,0,1,1,0,0,0,0,1,4'h0,0,0,0), "rsw_mem0");
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, 1'b0, v(0,0,1,1,0,0,0,0,1,4'h0,0,0,0), "rsw_mem1");
    push(1'b1, 32'h0020A023, 1'b1, 1'b0, 1'b0, e_zero, "rsw_reset_drop");
    push(1'b0, 32'h0020A023, 1'b1, 1'b1, 1'b0, e_zero, "rsw_start");
    push(1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, e_fetch_wait, "rsw_refetch");
    push_fd(32'h0020A023);
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,1,4'h0,0,0,0), "rsw2_exec");
    push(1'b0, 32'h0020A023, 1'b1, 1'b1, 1'b0, v(0,0,1,1,0,1,0,0,1,4'h0,0,1,0), "rsw2_mem");
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s; logic [18:0] obs;
    logic [31:0] bad [8];
    bad = '{32'h0000007F, 32'h0000B103, 32'h0000E103, 32'h0000B023,
            32'h0000C023, 32'h0000A463, 32'h0000B463, 32'h000010E7};
    for (int i = 0; i < 8; i++) begin
      push(1'b1, bad[i], 1'b0, 1'b0, 1'b0, e_zero, "ill_reset");
      push(1'b0, bad[i], 1'b0, 1'b0, 1'b0, e_zero, "ill_start");
      push_fd(bad[i]);
      for (int k = 0; k < ((i == 7) ? 12 : 2); k++)
        push(1'b0, bad[i], 1'b1, 1'b1, 1'b1, e_trap, $sformatf("trap_%08h", bad[i]));
    end
    while (sb.size() > 0) begin
      s = sb.pop_front(); drive_sample(s, obs); n_cmp++;
      if (obs !== s.exp) begin
        n_err++; $display("FAIL %s: got %05h want %05h", s.tag, obs, s.exp);
      end
    end
  endtask

  initial begin
    e_zero       = v(0,0,0,0,0,0,0,0,0,4'h0,0,0,0);
    e_fetch      = v(1,1,0,0,0,0,0,0,0,4'h0,0,0,0);
    e_fetch_wait = v(1,0,0,0,0,0,0,0,0,4'h0,0,0,0);
    e_wb_alu     = v(0,0,0,0,1,1,0,0,0,4'h0,0,1,0);
    e_trap       = v(0,0,0,0,0,0,0,0,0,4'h0,0,0,1);
    test_reset();
    test_addi();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_jumps_upper();
    test_store_wait();
    test_reset_mid_mem();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It fetches each instruction into the instruction register, lets the immediate extender and register file settle in a decode cycle, then sequences the ALU, data memory, register writeback and PC update. Memory ports use a req/ready handshake, so wait states are tolerated. Sits between the instruction register/extender and the shared datapath muxes.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_code  in  32  instruction register output; stable from DECODE until the next FETCH completes
- imem_ready  in  1  instruction memory has valid data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- branch_taken  in  1  branch comparator result for rs1/rs2 under funct3
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (stores)
- rf_we  out  1  register file write
- pc_we  out  1  PC update
- pc_src  out  2  0: PC+4, 1: PC+imm, 2: ALU result & ~1
- alu_src_a  out  2  0: rs1, 1: PC, 2: zero
- alu_src_b  out  1  0: rs2, 1: imm_ext
- alu_op  out  4  {op_mod, funct3}
- wb_sel  out  2  0: ALU, 1: load data, 2: PC+4
- retired  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky; an unsupported encoding was decoded

## Operation
- Opcodes: R 0110011, I_ARITH 0010011, LOAD 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- State register states: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Outputs are combinational from the state register and instr_code. Every output not listed for a state is 0.
- START: go to FETCH.
- FETCH: imem_req=1. When imem_ready=1: ir_we=1 and go to DECODE. Otherwise hold in FETCH.
- DECODE: no outputs. On an illegal encoding go to TRAP; otherwise go to EXECUTE. Illegal encodings:
  - unknown opcode
  - LOAD funct3 ∈ {011,110,111}
  - S funct3 > 010
  - B funct3 ∈ {010,011}
  - JALR funct3 ≠ 000
- EXECUTE:
  - ALU operand and op selection:
    - R: a=0, b=0, alu_op={funct7[5],funct3}.
    - I_ARITH: a=0, b=1. op_mod=funct7[5] only when funct3=101; otherwise 0.
    - LOAD/S: a=0, b=1, alu_op=0000.
    - LUI: a=2, b=1, op 0000.
    - AUIPC: a=1, b=1, op 0000.
    - JALR: a=0, b=1, op 0000.
  - Next state:
    - R, I_ARITH, LUI, AUIPC, JAL, JALR: go to WRITEBACK.
    - LOAD, S: go to MEM.
    - B: pc_we=1, pc_src = branch_taken ? 1 : 0, retired=1, go to FETCH.
- MEM: dmem_req=1 and dmem_we=(opcode==S). alu_src_a/alu_src_b/alu_op are held at their EXECUTE values so the address stays stable. Hold until dmem_ready=1, then:
  - S: pc_we=1, pc_src=0, retired=1, go to FETCH.
  - LOAD: go to WRITEBACK.
- WRITEBACK: rf_we=1, pc_we=1, retired=1, go to FETCH. Selections by opcode:
  - LOAD: wb_sel=1.
  - JAL: wb_sel=2, pc_src=1.
  - JALR: wb_sel=2, pc_src=2. ALU selections are held from EXECUTE.
  - Otherwise: wb_sel=0, pc_src=0.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.

## Timing
- Reset: state becomes START immediately, asynchronously. All outputs are 0 while reset is high and in the first cycle after release.
- Zero-wait memory latency, FETCH through the retiring cycle:
  - B: 3 cycles
  - S: 4 cycles
  - R / I / U / J: 4 cycles
  - LOAD: 5 cycles
- Each cycle of imem_ready=0 or dmem_ready=0 adds one cycle.
- imem_req and dmem_req stay high continuously until ready. They never drop mid-handshake except on reset.
- ready asserted while the matching req is low is ignored.
- Reset asserted mid-FETCH or mid-MEM drops the request in the same cycle.
- pc_we and retired are asserted in exactly one cycle per instruction, the same cycle. rf_we is never asserted for S or B.
- illegal rises on the edge leaving DECODE.

## Test plan
- Reset, then instr_code=0x00500093 (addi x1,x0,5), imem_ready=1 always.
  - START→FETCH→DECODE→EXECUTE→WRITEBACK.
  - EXECUTE: alu_src_b=1, alu_op=0000.
  - WRITEBACK: rf_we=1, wb_sel=0, pc_we=1, retired=1.
- 0x4020D093 (srai x1,x1,2) → alu_op=1101. Also 0x40208033 (sub) → alu_op=1000.
- 0x0000A103 (lw) with dmem_ready low for 3 MEM cycles:
  - dmem_req stays high for 4 cycles with dmem_we=0.
  - Then WRITEBACK with wb_sel=1.
  - 8 cycles total.
- 0x00208463 (beq):
  - branch_taken=1 → pc_src=1, pc_we=1 in EXECUTE.
  - branch_taken=0 → pc_src=0.
  - rf_we=0 in both cases.
- 0x000000E7 (jalr x1,0(x0)): WRITEBACK has wb_sel=2, pc_src=2, rf_we=1. 0x000010E7 (funct3=001) → TRAP, illegal=1 held for 10+ cycles.
- Assert reset during MEM of a store: dmem_req and dmem_we drop immediately. After release: 1 START cycle, then imem_req=1.
